// File: rtl/present_cipher_core.sv
// PRESENT-80/128 encrypt/decrypt engine: one round per clock; the expanded decryption key is cached.
// Latency: NUM_ROUNDS cycles (encrypt, or cached decrypt), 2*NUM_ROUNDS (decrypt miss). One job in flight; the result is held until out_ready.
module present_cipher_core #(
    parameter int KEY_WIDTH  = 80,
    parameter int NUM_ROUNDS = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_decrypt,
    input  logic [63:0]          in_data,
    input  logic [KEY_WIDTH-1:0] in_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_data,
    output logic                 busy,
    output logic                 cache_hit
);
    localparam int KW = KEY_WIDTH;
    localparam int RC_LO = (KW == 128) ? 62 : 15;
    localparam logic [4:0] LAST = 5'(NUM_ROUNDS);
    localparam logic [63:0] SBOX_TBL = 64'hC56B90AD3EF84712;
    localparam logic [63:0] SBOX_INV_TBL = 64'h5EF8C12DB463079A;

    if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
        $error("present_cipher_core: KEY_WIDTH must be 80 or 128");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_num_rounds
        $error("present_cipher_core: NUM_ROUNDS must be in 1..31");
    end

    typedef enum logic [1:0] {IDLE, KEYEXP, RUN, DONE} state_t;

    // Table nibble 15 holds S(0), so index with the inverted input.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TBL[{~x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        return SBOX_INV_TBL[{~x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] s_layer_inv(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox_inv(x[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        y[63] = x[63];
        for (int j = 0; j < 63; j++) y[(16*j) % 63] = x[j];
        return y;
    endfunction

    function automatic logic [63:0] p_layer_inv(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        y[63] = x[63];
        for (int j = 0; j < 63; j++) y[j] = x[(16*j) % 63];
        return y;
    endfunction

    function automatic logic [KW-1:0] key_fwd(input logic [KW-1:0] k, input logic [4:0] i);
        logic [KW-1:0] r;
        r = {k[KW-62:0], k[KW-1:KW-61]};
        r[KW-1 -: 4] = sbox(r[KW-1 -: 4]);
        if (KW == 128) r[KW-5 -: 4] = sbox(r[KW-5 -: 4]);
        r[RC_LO +: 5] = r[RC_LO +: 5] ^ i;
        return r;
    endfunction

    function automatic logic [KW-1:0] key_inv(input logic [KW-1:0] k, input logic [4:0] i);
        logic [KW-1:0] r;
        r = k;
        r[RC_LO +: 5] = r[RC_LO +: 5] ^ i;
        r[KW-1 -: 4] = sbox_inv(r[KW-1 -: 4]);
        if (KW == 128) r[KW-5 -: 4] = sbox_inv(r[KW-5 -: 4]);
        return {r[60:0], r[KW-1:61]};
    endfunction

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [KW-1:0] key_q, key_d;
    logic [63:0]   s_q, s_d;
    logic          dec_q, dec_d;
    logic [63:0]   out_data_q, out_data_d;
    logic          cache_valid_q, cache_valid_d;
    logic [KW-1:0] cached_key_q, cached_key_d;
    logic [KW-1:0] last_key_q, last_key_d;
    logic          cache_hit_q, cache_hit_d;

    logic [KW-1:0] key_f, key_i;
    logic [63:0]   rk, s_enc, s_dec;
    logic          hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            key_q         <= '0;
            s_q           <= '0;
            dec_q         <= 1'b0;
            out_data_q    <= '0;
            cache_valid_q <= 1'b0;
            cached_key_q  <= '0;
            last_key_q    <= '0;
            cache_hit_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_q         <= key_d;
            s_q           <= s_d;
            dec_q         <= dec_d;
            out_data_q    <= out_data_d;
            cache_valid_q <= cache_valid_d;
            cached_key_q  <= cached_key_d;
            last_key_q    <= last_key_d;
            cache_hit_q   <= cache_hit_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        key_d         = key_q;
        s_d           = s_q;
        dec_d         = dec_q;
        out_data_d    = out_data_q;
        cache_valid_d = cache_valid_q;
        cached_key_d  = cached_key_q;
        last_key_d    = last_key_q;
        cache_hit_d   = 1'b0;

        key_f = key_fwd(key_q, cnt_q);
        key_i = key_inv(key_q, cnt_q);
        rk    = key_q[KW-1 -: 64];
        s_enc = p_layer(s_layer(s_q ^ rk));
        s_dec = s_layer_inv(p_layer_inv(s_q ^ rk));
        hit   = cache_valid_q && (cached_key_q == in_key);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d   = in_data;
                    dec_d = in_decrypt;
                    if (!in_decrypt) begin
                        state_d = RUN;
                        key_d   = in_key;
                        cnt_d   = 5'd1;
                    end else if (hit) begin
                        state_d     = RUN;
                        key_d       = last_key_q;
                        cnt_d       = LAST;
                        cache_hit_d = 1'b1;
                    end else begin
                        // The cache is rewritten up front and only marked valid once expansion completes.
                        state_d       = KEYEXP;
                        key_d         = in_key;
                        cnt_d         = 5'd1;
                        cache_valid_d = 1'b0;
                        cached_key_d  = in_key;
                    end
                end
            end
            KEYEXP: begin
                key_d = key_f;
                if (cnt_q == LAST) begin
                    state_d       = RUN;
                    cnt_d         = LAST;
                    last_key_d    = key_f;
                    cache_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            RUN: begin
                if (!dec_q) begin
                    s_d   = s_enc;
                    key_d = key_f;
                    if (cnt_q == LAST) begin
                        state_d    = DONE;
                        out_data_d = s_enc ^ key_f[KW-1 -: 64];
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else begin
                    // Decrypt walks the schedule backwards: cnt is the step being undone.
                    s_d   = s_dec;
                    key_d = key_i;
                    if (cnt_q == 5'd1) begin
                        state_d    = DONE;
                        out_data_d = s_dec ^ key_i[KW-1 -: 64];
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign cache_hit = cache_hit_q;

endmodule
